// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiply / restoring divide unit owning HI/LO.
// One step per cycle; stalls the core while busy if it touches HI/LO or issues another op.
`default_nettype none

module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];
    assign abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Multiply: {acc,mq} shifts right, multiplier bits consumed from mq[0].
    assign sum    = {1'b0, acc_q} + (mq_q[0] ? {1'b0, d_q} : {(WIDTH+1){1'b0}});
    // Divide: {acc,mq} shifts left, quotient bits enter at mq[0].
    assign rem_sh = {acc_q, mq_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, d_q};

    assign prod     = {acc_q, mq_q};
    assign prod_fix = neg_res_q ? -prod : prod;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        d_d       = d_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start) begin
                    op_d    = op;
                    a_d     = srca;
                    b_d     = srcb;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                d_d       = abs_b;
                mq_d      = abs_a;
                acc_d     = '0;
                cnt_d     = '0;
                neg_res_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = is_signed & is_div & a_q[WIDTH-1];
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (is_div) begin
                    acc_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], ~diff[WIDTH]};
                end else begin
                    acc_d = sum[WIDTH:1];
                    mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_q == '0) begin
                    // Divide by zero: all-ones quotient, dividend returned unchanged.
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = neg_res_q ? -mq_q : mq_q;
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            d_q       <= d_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != S_IDLE);
    assign stall = busy & (start | rd_req | wr_hi | wr_lo);
    assign done  = done_q;

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its sequencing controller. It owns the HI/LO registers of the MIPS core.
- Sits beside the single-cycle datapath. Decode issues MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO requests to it.
- While an operation is in flight, it stalls the core whenever the core touches HI/LO or issues another mul/div.
- Built so the Multiplication test program can run on hardware without a combinational 32x32 multiplier.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; operands and op sampled on the accepting edge.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- srca  in  WIDTH  multiplicand / dividend (rs).
- srcb  in  WIDTH  multiplier / divisor (rt).
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- rd_req  in  1  current instruction is MFHI/MFLO.
- hi  out  WIDTH  HI register (product high / remainder).
- lo  out  WIDTH  LO register (product low / quotient).
- busy  out  1  operation in flight.
- stall  out  1  freeze the core PC/register writes this cycle.
- done  out  1  one-cycle pulse after HI/LO are updated by an operation.

Behaviour:
- Reset (async, any state): state=IDLE; hi=lo=0; counter=0; busy=0; done=0; all internal operand/accumulator registers cleared. A reset during an operation aborts it; no partial result reaches hi/lo.
- States:
  - IDLE: busy=0. If start=1, latch op/srca/srcb and go to PREP.
  - PREP (1 cycle): for signed ops, take absolute values and record result sign (and remainder sign for DIV). Clear accumulator and counter. Go to RUN.
  - RUN (exactly WIDTH cycles): one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle. The counter increments 0..WIDTH-1. On the edge where counter==WIDTH-1, go to FIX.
  - FIX (1 cycle): apply sign correction, write hi/lo on the exiting edge, go to IDLE, done=1 in the following cycle only.
- Latency: start sampled at edge N. hi/lo hold the new result after edge N+WIDTH+2 (N+34 at default). busy is high for cycles N+1 .. N+WIDTH+2, i.e. in PREP, RUN and FIX.
- stall = busy & (start | rd_req | wr_hi | wr_lo), combinational. The core holds the instruction, so it is re-presented when busy falls.
- start while busy: ignored (not queued).
- wr_hi/wr_lo while busy: ignored (the core is stalled).
- wr_hi/wr_lo in IDLE: write wdata on the edge. If start is also asserted on that edge, the write happens and the operation starts; its result later overwrites both hi and lo.
- MULTU: {hi,lo} = srca*srcb, unsigned, 2*WIDTH bits.
- MULT: two's-complement 2*WIDTH-bit product.
- DIVU: lo = srca/srcb, hi = srca%srcb, unsigned.
- DIV: quotient truncates toward zero; remainder has the sign of the dividend.
- Divide by zero (either div op): lo = all ones, hi = srca. Full latency still applies.
- DIV overflow (srca = 0x80000000, srcb = 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- hi/lo are never modified outside FIX or an IDLE MTHI/MTLO write. They remain readable (stable) throughout an operation.

Test Plan:
- Reset, then MULTU srca=7, srcb=6 -> busy rises next cycle; after 34 edges lo=0x0000002A, hi=0; done pulses exactly 1 cycle.
- MULT srca=0xFFFFFFFD (-3), srcb=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=0x0000000E, hi=0x00000002. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234, after the full 34 cycles.
- Start MULTU, hold rd_req=1 -> stall=1 every busy cycle and 0 in the cycle done=1. A second start and wr_lo during busy -> no effect on state, hi or lo.
- Start DIVU 100/7, assert reset at RUN cycle 10 -> immediately busy=0, hi=lo=0, done never pulses. A fresh MTLO 0x55 in IDLE -> lo=0x55 next edge.
